// File: rtl/ex_flag_stage_if.sv
// Execute-to-EX/MEM bus: EX instruction payload in, pipeline register and flags out.
interface ex_flag_stage_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
);
    logic          valid_in;
    logic [3:0]    opcode_in;
    logic [DW-1:0] alu_res_in;
    logic [DW-1:0] shift_res_in;
    logic          ovf_in;
    logic [RW-1:0] rd_in;
    logic          wr_en_in;
    logic          stall;
    logic          flush;
    logic          valid_out;
    logic [DW-1:0] res_out;
    logic [RW-1:0] rd_out;
    logic          wr_en_out;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;

    modport master (
        output valid_in, opcode_in, alu_res_in, shift_res_in, ovf_in,
               rd_in, wr_en_in, stall, flush,
        input  valid_out, res_out, rd_out, wr_en_out, flag_z, flag_v, flag_n
    );

    modport slave (
        input  valid_in, opcode_in, alu_res_in, shift_res_in, ovf_in,
               rd_in, wr_en_in, stall, flush,
        output valid_out, res_out, rd_out, wr_en_out, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with result select and the architectural Z/V/N flag register.
module ex_flag_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_flag_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;

    logic          r_valid;
    logic [DW-1:0] r_res;
    logic [RW-1:0] r_rd;
    logic          r_wr_en;
    logic          r_flag_z;
    logic          r_flag_v;
    logic          r_flag_n;

    logic [DW-1:0] w_sel;
    logic          w_upd_zn;
    logic          w_upd_z;
    logic          w_zero;

    // Opcode decode: unlisted or unknown opcodes take the ALU path and touch no flags.
    always_comb begin
        w_sel    = bus.alu_res_in;
        w_upd_zn = 1'b0;
        w_upd_z  = 1'b0;
        case (bus.opcode_in)
            OP_ADD, OP_SUB: w_upd_zn = 1'b1;
            OP_XOR:         w_upd_z  = 1'b1;
            OP_SLL, OP_SRA, OP_ROR: begin
                w_sel   = bus.shift_res_in;
                w_upd_z = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_zero = (w_sel == DW'(0));

    // Flush kills even a stalled instruction; stall freezes everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_res    <= '0;
            r_rd     <= '0;
            r_wr_en  <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_v <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (!bus.stall) begin
            r_valid <= bus.valid_in;
            r_wr_en <= bus.valid_in & bus.wr_en_in;
            r_res   <= w_sel;
            r_rd    <= bus.rd_in;
            if (bus.valid_in) begin
                if (w_upd_zn) begin
                    r_flag_z <= w_zero;
                    r_flag_n <= w_sel[DW-1];
                    r_flag_v <= bus.ovf_in;
                end else if (w_upd_z) begin
                    r_flag_z <= w_zero;
                end
            end
        end
    end

    assign bus.valid_out = r_valid;
    assign bus.res_out   = r_res;
    assign bus.rd_out    = r_rd;
    assign bus.wr_en_out = r_wr_en;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_v    = r_flag_v;
    assign bus.flag_n    = r_flag_n;
endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: result select, flag qualification, stall/flush, reset.
module tb_ex_flag_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    ex_flag_stage_if #(.DW(16), .RW(4)) bus ();

    ex_flag_stage #(.DW(16), .RW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed state packed as {valid, wr_en, res[15:0], rd[3:0], z, v, n}.
    logic [24:0] obs;
    logic [24:0] exp_v;
    assign obs = {bus.valid_out, bus.wr_en_out, bus.res_out, bus.rd_out,
                  bus.flag_z, bus.flag_v, bus.flag_n};

    task automatic drive(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sh,
                         input logic ovf, input logic [3:0] rd, input logic wr,
                         input logic v, input logic st, input logic fl);
        @(negedge clk);
        bus.opcode_in    = op;
        bus.alu_res_in   = alu;
        bus.shift_res_in = sh;
        bus.ovf_in       = ovf;
        bus.rd_in        = rd;
        bus.wr_en_in     = wr;
        bus.valid_in     = v;
        bus.stall        = st;
        bus.flush        = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'h0, 3'b000};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL reset_init: got %h want %h", obs, exp_v); end
        @(negedge clk); rst_n = 1'b1;
        // ADD result 0 sets Z and valid, then async reset clears mid-cycle.
        drive(4'b0000, 16'h0000, 16'h5555, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'h7, 3'b100};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL reset_pre: got %h want %h", obs, exp_v); end
        #2 rst_n = 1'b0;
        #1;
        exp_v = {1'b0, 1'b0, 16'h0000, 4'h0, 3'b000};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL reset_async: got %h want %h", obs, exp_v); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(4'b0000, 16'h8000, 16'h0001, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h8000, 4'h3, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL add_neg_ovf: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_sll();
        drive(4'b0100, 16'h1234, 16'h0000, 1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'h5, 3'b111};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL sll_zero: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_stall();
        drive(4'b0000, 16'h0001, 16'h0000, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0001, 4'h1, 3'b000};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL stall_setup: got %h want %h", obs, exp_v); end
        drive(4'b0001, 16'h0000, 16'hFFFF, 1'b0, 4'h9, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, exp_v); end
        end
        @(negedge clk); bus.stall = 1'b0;
        step();
        exp_v = {1'b1, 1'b0, 16'h0000, 4'h9, 3'b100};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL stall_release: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_flush();
        drive(4'b0000, 16'h0005, 16'h0000, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0005, 4'h2, 3'b000};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL flush_setup: got %h want %h", obs, exp_v); end
        drive(4'b0010, 16'h0000, 16'h0000, 1'b0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        n_cmp++;
        if ({bus.valid_out, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n} !== 5'b00000) begin
            n_bad++;
            $display("FAIL flush_kill: got %b want 00000",
                     {bus.valid_out, bus.wr_en_out, bus.flag_z, bus.flag_v, bus.flag_n});
        end
    endtask

    task automatic test_paddsb();
        drive(4'b0000, 16'h8000, 16'h0000, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h8000, 4'h4, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL paddsb_setup: got %h want %h", obs, exp_v); end
        drive(4'b0111, 16'h0000, 16'hFFFF, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'h6, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL paddsb_noflag: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        drive(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'hA, 3'b100};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_add: got %h want %h", obs, exp_v); end
        drive(4'b0001, 16'hFFFE, 16'h0000, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'hFFFE, 4'hB, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_sub: got %h want %h", obs, exp_v); end
        drive(4'b0010, 16'hFFFF, 16'h0000, 1'b0, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b0, 16'hFFFF, 4'hC, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_xor: got %h want %h", obs, exp_v); end
        drive(4'b0110, 16'h1111, 16'h0000, 1'b0, 4'hD, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'hD, 3'b111};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_ror: got %h want %h", obs, exp_v); end
        drive(4'b0101, 16'h0000, 16'h8001, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h8001, 4'hE, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_sra: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_bubble();
        drive(4'b0000, 16'h0000, 16'h0000, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        exp_v = {1'b0, 1'b0, 16'h0000, 4'h8, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL bubble: got %h want %h", obs, exp_v); end
        drive(4'b1001, 16'h0000, 16'h7777, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'h1, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL op_high: got %h want %h", obs, exp_v); end
        drive(4'b0011, 16'h0000, 16'h0000, 1'b0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        exp_v = {1'b1, 1'b1, 16'h0000, 4'h2, 3'b011};
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL red_noflag: got %h want %h", obs, exp_v); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.opcode_in = 4'h0; bus.alu_res_in = 16'h0;
        bus.shift_res_in = 16'h0; bus.ovf_in = 1'b0; bus.rd_in = 4'h0;
        bus.wr_en_in = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        test_reset();
        test_add();
        test_sll();
        test_stall();
        test_flush();
        test_paddsb();
        test_back_to_back();
        test_bubble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
